// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_sequencer
// Description : Streams one frame of pixels from an input memory through a
//               convolutional layer and writes the layer results to an
//               output memory, with flow control and a drain-timeout guard.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_sequencer #(
    parameter int I_WIDTH      = 8,
    parameter int O_WIDTH      = 16,
    parameter int CHANNELS_IN  = 3,
    parameter int CHANNELS_OUT = 5,
    parameter int FILTER_SIZE  = 5,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 32,
    parameter int STRIDE       = 4,
    parameter int DRAIN_LIMIT  = 1024
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error,
    output logic                                    in_rd_en,
    output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT)-1:0] in_rd_addr,
    input  logic [CHANNELS_IN*I_WIDTH-1:0]          in_rd_data,
    output logic                                    layer_clk_en,
    output logic [CHANNELS_IN*I_WIDTH-1:0]          layer_input_data,
    input  logic [CHANNELS_OUT*O_WIDTH-1:0]         layer_output_data,
    input  logic                                    layer_valid,
    input  logic                                    out_ready,
    output logic                                    out_wr_en,
    output logic [$clog2(((IMAGE_WIDTH-FILTER_SIZE+1)/STRIDE)*((IMAGE_HEIGHT-FILTER_SIZE+1)/STRIDE))-1:0] out_wr_addr,
    output logic [CHANNELS_OUT*O_WIDTH-1:0]         out_wr_data
);

    localparam int N_IN  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int N_OUT = ((IMAGE_WIDTH - FILTER_SIZE + 1) / STRIDE) *
                           ((IMAGE_HEIGHT - FILTER_SIZE + 1) / STRIDE);
    localparam int AW    = $clog2(N_IN);
    localparam int OW    = $clog2(N_OUT);
    localparam int DW    = $clog2(DRAIN_LIMIT + 1);

    // Counters carry one extra bit so the terminal counts are representable.
    localparam logic [AW:0]   RD_END     = (AW+1)'(N_IN);
    localparam logic [OW:0]   WR_END     = (OW+1)'(N_OUT);
    localparam logic [OW:0]   WR_LAST    = (OW+1)'(N_OUT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW:0]     rd_ptr;
    logic [OW:0]     wr_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            rd_pending;     // a read was issued and its data is not yet captured
    logic            advance;
    logic            reads_left;
    logic            wr_fire;
    logic            last_write;
    logic            drain_timeout;
    logic            frame_start;

    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);
    assign in_rd_addr  = rd_ptr[AW-1:0];
    assign out_wr_en   = wr_fire;
    assign out_wr_addr = wr_cnt[OW-1:0];
    assign out_wr_data = layer_output_data;

    // Flow-control decode: advance gates every read, layer step and write.
    // Holding rst_n low also blocks advance so an aborted frame issues no
    // further accesses on the reset edge itself.
    always_comb begin
        advance       = 1'b0;
        in_rd_en      = 1'b0;
        layer_clk_en  = 1'b0;
        if (rst_n && out_ready &&
            (state == FILL || state == STREAM || state == DRAIN)) begin
            advance = 1'b1;
        end
        reads_left = (rd_ptr < RD_END);
        case (state)
            FILL:    in_rd_en = advance;
            STREAM: begin
                layer_clk_en = advance;
                in_rd_en     = advance && reads_left;
            end
            DRAIN:   layer_clk_en = advance;
            default: ;
        endcase
        wr_fire       = layer_valid && layer_clk_en && (wr_cnt < WR_END);
        last_write    = wr_fire && (wr_cnt == WR_LAST);
        drain_timeout = (state == DRAIN) && advance &&
                        (drain_cnt == DRAIN_LAST) && !last_write;
        frame_start   = (state == IDLE) && start;
    end

    // Next-state logic; the final write wins over any drain transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (advance) state_next = STREAM;
            STREAM: begin
                if (last_write) begin
                    state_next = FINISH;
                end else if (advance && !reads_left && !rd_pending) begin
                    // the last pixel is on the layer input this cycle
                    state_next = DRAIN;
                end
            end
            DRAIN:   if (last_write || drain_timeout) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read side: address pointer and the pixel register feeding the layer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr           <= '0;
            rd_pending       <= 1'b0;
            layer_input_data <= '0;
        end else if (frame_start) begin
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (in_rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (advance) begin
                rd_pending <= in_rd_en;
                if (rd_pending) begin
                    layer_input_data <= in_rd_data;
                end
            end
        end
    end

    // Write side: output address, drain cycle counter and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            drain_cnt <= '0;
            error     <= 1'b0;
        end else if (frame_start) begin
            wr_cnt    <= '0;
            drain_cnt <= '0;
            error     <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + (OW+1)'(1);
            end
            if (state == DRAIN && advance) begin
                drain_cnt <= drain_cnt + DW'(1);
            end
            if (drain_timeout) begin
                error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
